// File: rtl/decode_pkg.sv
// decode_pkg: opcode, writeback-select and memory-request encodings, plus
// the opcode-to-control decode used by the decode stage.
package decode_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'h33;
    localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
    localparam logic [6:0] OPCODE_LUI    = 7'h37;
    localparam logic [6:0] OPCODE_LOAD   = 7'h03;
    localparam logic [6:0] OPCODE_STORE  = 7'h23;
    localparam logic [6:0] OPCODE_JAL    = 7'h6F;
    localparam logic [6:0] OPCODE_JALR   = 7'h67;
    localparam logic [6:0] OPCODE_BRANCH = 7'h63;

    localparam logic [1:0] WB_NONE = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_MEM  = 2'd2;
    localparam logic [1:0] WB_PC4  = 2'd3;

    localparam logic MEM_REQ_READ  = 1'b0;
    localparam logic MEM_REQ_WRITE = 1'b1;

    typedef struct packed {
        logic       legal;
        logic       is_jal;
        logic       use_rs1;
        logic       use_rs2;
        logic       rf_wr_en;
        logic       mem_req;
        logic       mem_req_type;
        logic [1:0] wb_sel;
    } ctrl_t;

    // Unknown opcodes decode to an all-inactive control word with legal=0.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
        ctrl_t c;
        c = '0;
        c.legal = 1'b1;
        c.mem_req_type = MEM_REQ_READ;
        case (opcode)
            OPCODE_OP: begin
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.rf_wr_en = 1'b1; c.wb_sel = WB_ALU;
            end
            OPCODE_OP_IMM: begin
                c.use_rs1 = 1'b1; c.rf_wr_en = 1'b1; c.wb_sel = WB_ALU;
            end
            OPCODE_LUI: begin
                c.rf_wr_en = 1'b1; c.wb_sel = WB_ALU;
            end
            OPCODE_LOAD: begin
                c.use_rs1 = 1'b1; c.rf_wr_en = 1'b1; c.wb_sel = WB_MEM; c.mem_req = 1'b1;
            end
            OPCODE_STORE: begin
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1; c.mem_req = 1'b1;
                c.mem_req_type = MEM_REQ_WRITE;
            end
            OPCODE_JAL: begin
                c.is_jal = 1'b1; c.rf_wr_en = 1'b1; c.wb_sel = WB_PC4;
            end
            OPCODE_JALR: begin
                c.use_rs1 = 1'b1; c.rf_wr_en = 1'b1; c.wb_sel = WB_PC4;
            end
            OPCODE_BRANCH: begin
                c.use_rs1 = 1'b1; c.use_rs2 = 1'b1;
            end
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// decode_scoreboard: per-register pending-write counters with netted
// increment / writeback / rollback updates, busy vector and hazard lookups.
module decode_scoreboard #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PEND_W = 2,
    localparam int         NREG   = 1 << REG_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              inc_en,
    input  logic [REG_AW-1:0] inc_wd,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_wd,
    input  logic              rb_en,
    input  logic [REG_AW-1:0] rb_wd,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] wd,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              wd_full,
    output logic [NREG-1:0]   sb_busy
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];

    // Net all same-cycle events per register, then clamp to [0, max]; x0 stays 0.
    always_comb begin
        int net;
        net = 0;
        pend_d[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            net = int'(pend_q[i]);
            if (inc_en && inc_wd == REG_AW'(i)) net = net + 1;
            if (wb_valid && wb_wd == REG_AW'(i)) net = net - 1;
            if (rb_en && rb_wd == REG_AW'(i)) net = net - 1;
            if (net < 0) begin
                pend_d[i] = '0;
            end else if (net > int'(PEND_MAX)) begin
                pend_d[i] = PEND_MAX;
            end else begin
                pend_d[i] = PEND_W'(net);
            end
        end
    end

    // Counter array state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) pend_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) pend_q[i] <= pend_d[i];
        end
    end

    // Busy vector and hazard lookups straight from the registered counts.
    always_comb begin
        for (int i = 0; i < NREG; i++) sb_busy[i] = |pend_q[i];
        rs1_busy = |pend_q[rs1];
        rs2_busy = |pend_q[rs2];
        wd_full  = &pend_q[wd];
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode pipeline stage with valid/ready on both
// sides, flush, and a pending-write scoreboard that stalls on RAW hazards.
// Optional macro DECODE_ILLEGAL_EN adds the registered out_illegal flag.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned PEND_W = 2,
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INST_W-1:0]        in_inst,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    output logic [REG_AW-1:0]        out_rs1,
    output logic [REG_AW-1:0]        out_rs2,
    output logic [REG_AW-1:0]        out_wd,
    output logic [1:0]               out_wb_sel,
    output logic                     out_rf_wr_en,
    output logic                     out_mem_req,
    output logic                     out_mem_req_type,
    input  logic                     wb_valid,
    input  logic [REG_AW-1:0]        wb_wd,
    input  logic                     flush,
    output logic [(1 << REG_AW)-1:0] sb_busy
`ifdef DECODE_ILLEGAL_EN
    ,
    output logic                     out_illegal
`endif
);

    ctrl_t             ctrl;
    logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_wd;
    logic              rs1_busy, rs2_busy, wd_full;
    logic              hazard, accept, inc_en, rb_en;

    // Field decode, hazard check and handshake.
    always_comb begin
        ctrl    = decode_ctrl(in_inst[6:0]);
        dec_rs1 = REG_AW'(in_inst[26:22]);
        dec_rs2 = REG_AW'(in_inst[21:17]);
        dec_wd  = ctrl.is_jal ? REG_AW'(1) : REG_AW'(in_inst[31:27]);
        hazard  = (ctrl.use_rs1 && rs1_busy) || (ctrl.use_rs2 && rs2_busy) ||
                  (ctrl.rf_wr_en && dec_wd != '0 && wd_full);
        in_ready = reset_n && !hazard && !flush && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        inc_en   = accept && ctrl.rf_wr_en && dec_wd != '0;
        // A squashed bundle that would have written gives its reservation back.
        rb_en    = flush && out_valid && out_rf_wr_en && out_wd != '0;
    end

    decode_scoreboard #(
        .REG_AW (REG_AW),
        .PEND_W (PEND_W)
    ) u_sb (
        .clk      (clk),
        .reset_n  (reset_n),
        .inc_en   (inc_en),
        .inc_wd   (dec_wd),
        .wb_valid (wb_valid),
        .wb_wd    (wb_wd),
        .rb_en    (rb_en),
        .rb_wd    (out_wd),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .wd       (dec_wd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .wd_full  (wd_full),
        .sb_busy  (sb_busy)
    );

    // Pipeline register: load on accept, drop on flush or when taken, else hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid        <= 1'b0;
            out_pc           <= '0;
            out_inst         <= '0;
            out_rs1          <= '0;
            out_rs2          <= '0;
            out_wd           <= '0;
            out_wb_sel       <= '0;
            out_rf_wr_en     <= 1'b0;
            out_mem_req      <= 1'b0;
            out_mem_req_type <= 1'b0;
        end else if (accept) begin
            out_valid        <= 1'b1;
            out_pc           <= in_pc;
            out_inst         <= in_inst;
            out_rs1          <= dec_rs1;
            out_rs2          <= dec_rs2;
            out_wd           <= dec_wd;
            out_wb_sel       <= ctrl.wb_sel;
            out_rf_wr_en     <= ctrl.rf_wr_en;
            out_mem_req      <= ctrl.mem_req;
            out_mem_req_type <= ctrl.mem_req_type;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_ILLEGAL_EN
    // Illegal-opcode flag travels with the bundle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_illegal <= !ctrl.legal;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table vectors, directed multi-cycle sequences and random
// traffic, all checked against a count-based model of the decode stage.
`timescale 1ns/1ps
module tb_decode_stage;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [4:0]  out_rs1, out_rs2, out_wd;
    logic [1:0]  out_wb_sel;
    logic        out_rf_wr_en, out_mem_req, out_mem_req_type;
    logic        wb_valid;
    logic [4:0]  wb_wd;
    logic        flush;
    logic [31:0] sb_busy;
`ifdef DECODE_ILLEGAL_EN
    logic        out_illegal;
`endif

    decode_stage dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_inst          (in_inst),
        .in_pc            (in_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_inst         (out_inst),
        .out_rs1          (out_rs1),
        .out_rs2          (out_rs2),
        .out_wd           (out_wd),
        .out_wb_sel       (out_wb_sel),
        .out_rf_wr_en     (out_rf_wr_en),
        .out_mem_req      (out_mem_req),
        .out_mem_req_type (out_mem_req_type),
        .wb_valid         (wb_valid),
        .wb_wd            (wb_wd),
        .flush            (flush),
        .sb_busy          (sb_busy)
`ifdef DECODE_ILLEGAL_EN
        ,
        .out_illegal      (out_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LUI = 7'h37, LD = 7'h03;
    localparam logic [6:0] ST = 7'h23, JAL = 7'h6F, JALR = 7'h67, BR = 7'h63, BAD = 7'h7F;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0] rs1, rs2, wd;
        logic [1:0] wb;
        logic       rf, mem, mt, u1, u2, ill;
    } dec_t;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rs1, rs2, wd;
        logic [1:0]  wb;
        logic        rf, mem, mt;
    } vec_t;

    // Model state: outstanding writes per register as plain integers.
    int          pend [32];
    logic        m_valid, m_rf, m_mem, m_mt, m_ill;
    logic [31:0] m_pc, m_inst;
    logic [4:0]  m_rs1, m_rs2, m_wd;
    logic [1:0]  m_wb;

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [6:0] op);
        return {rd, r1, r2, 10'h2A5, op};
    endfunction

    function automatic dec_t mdec(input logic [31:0] inst);
        dec_t d;
        d.rs1 = inst[26:22]; d.rs2 = inst[21:17]; d.wd = inst[31:27];
        d.wb = 2'd0; d.rf = 0; d.mem = 0; d.mt = 0; d.u1 = 0; d.u2 = 0; d.ill = 0;
        case (inst[6:0])
            OP:      begin d.u1 = 1; d.u2 = 1; d.rf = 1; d.wb = 2'd1; end
            OPI:     begin d.u1 = 1; d.rf = 1; d.wb = 2'd1; end
            LUI:     begin d.rf = 1; d.wb = 2'd1; end
            LD:      begin d.u1 = 1; d.rf = 1; d.wb = 2'd2; d.mem = 1; end
            ST:      begin d.u1 = 1; d.u2 = 1; d.mem = 1; d.mt = 1; end
            JAL:     begin d.wd = 5'd1; d.rf = 1; d.wb = 2'd3; end
            JALR:    begin d.u1 = 1; d.rf = 1; d.wb = 2'd3; end
            BR:      begin d.u1 = 1; d.u2 = 1; end
            default: d.ill = 1;
        endcase
        return d;
    endfunction

    function automatic logic model_ready();
        dec_t d;
        logic hz;
        d  = mdec(in_inst);
        hz = (d.u1 && pend[d.rs1] != 0) || (d.u2 && pend[d.rs2] != 0) ||
             (d.rf && d.wd != 0 && pend[d.wd] >= 3);
        return reset_n && !hz && !flush && (!m_valid || out_ready);
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        for (int i = 0; i < 32; i++) b[i] = (pend[i] != 0);
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) pend[i] = 0;
        m_valid = 0; m_rf = 0; m_mem = 0; m_mt = 0; m_ill = 0;
        m_pc = '0; m_inst = '0; m_rs1 = '0; m_rs2 = '0; m_wd = '0; m_wb = '0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("out_pc", 64'(out_pc), 64'(m_pc));
        chk("out_inst", 64'(out_inst), 64'(m_inst));
        chk("out_rs1", 64'(out_rs1), 64'(m_rs1));
        chk("out_rs2", 64'(out_rs2), 64'(m_rs2));
        chk("out_wd", 64'(out_wd), 64'(m_wd));
        chk("out_wb_sel", 64'(out_wb_sel), 64'(m_wb));
        chk("out_rf_wr_en", 64'(out_rf_wr_en), 64'(m_rf));
        chk("out_mem_req", 64'(out_mem_req), 64'(m_mem));
        chk("out_mem_req_type", 64'(out_mem_req_type), 64'(m_mt));
        chk("sb_busy", 64'(sb_busy), 64'(model_busy()));
`ifdef DECODE_ILLEGAL_EN
        chk("out_illegal", 64'(out_illegal), 64'(m_ill));
`endif
    endtask

    task automatic drv(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic wbv, input logic [4:0] wbwd,
                       input logic fl);
        in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy;
        wb_valid = wbv; wb_wd = wbwd; flush = fl;
    endtask

    // One clock: check in_ready before the edge, advance the model at the edge,
    // then check registered outputs just after it.
    task automatic cycle();
        dec_t d;
        logic acc;
        int   nd [32];
        @(negedge clk);
        acc = in_valid && model_ready();
        chk("in_ready", 64'(in_ready), 64'(model_ready()));
        d = mdec(in_inst);
        for (int i = 0; i < 32; i++) nd[i] = pend[i];
        if (acc && d.rf && d.wd != 0) nd[d.wd]++;
        if (wb_valid && wb_wd != 0) nd[wb_wd]--;
        if (flush && m_valid && m_rf && m_wd != 0) nd[m_wd]--;
        @(posedge clk);
        for (int i = 0; i < 32; i++) pend[i] = (nd[i] < 0) ? 0 : ((nd[i] > 3) ? 3 : nd[i]);
        if (acc) begin
            m_valid = 1; m_pc = in_pc; m_inst = in_inst; m_rs1 = d.rs1; m_rs2 = d.rs2;
            m_wd = d.wd; m_wb = d.wb; m_rf = d.rf; m_mem = d.mem; m_mt = d.mt; m_ill = d.ill;
        end else if (flush || out_ready) begin
            m_valid = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic [4:0] wbr);
        drv(0, '0, '0, 1, wbr != 0, wbr, 0);
        cycle();
    endtask

    vec_t       vt [9];
    logic [6:0] ops [9];
    logic [4:0] rsel [5];

    initial begin
        vt[0] = '{mk(3, 4, 5, OP),    5'd4,  5'd5,  5'd3,  2'd1, 1, 0, 0};
        vt[1] = '{mk(6, 7, 8, OPI),   5'd7,  5'd8,  5'd6,  2'd1, 1, 0, 0};
        vt[2] = '{mk(9, 1, 2, LUI),   5'd1,  5'd2,  5'd9,  2'd1, 1, 0, 0};
        vt[3] = '{mk(10, 3, 4, LD),   5'd3,  5'd4,  5'd10, 2'd2, 1, 1, 0};
        vt[4] = '{mk(11, 5, 6, ST),   5'd5,  5'd6,  5'd11, 2'd0, 0, 1, 1};
        vt[5] = '{mk(12, 7, 8, JAL),  5'd7,  5'd8,  5'd1,  2'd3, 1, 0, 0};
        vt[6] = '{mk(13, 9, 10, JALR), 5'd9, 5'd10, 5'd13, 2'd3, 1, 0, 0};
        vt[7] = '{mk(14, 11, 12, BR), 5'd11, 5'd12, 5'd14, 2'd0, 0, 0, 0};
        vt[8] = '{mk(15, 13, 14, BAD), 5'd13, 5'd14, 5'd15, 2'd0, 0, 0, 0};
        ops  = '{OP, OPI, LUI, LD, ST, JAL, JALR, BR, BAD};
        rsel = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd7};

        model_clear();
        reset_n = 0;
        drv(0, '0, '0, 0, 0, '0, 0);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(0));
        check_outputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        // Table vectors: writeback on the same register nets out the increment.
        for (int i = 0; i < 9; i++) begin
            drv(1, vt[i].inst, 32'h1000 + 32'(i * 4), 1, 1, vt[i].wd, 0);
            cycle();
            chk("tbl_valid", 64'(out_valid), 64'(1));
            chk("tbl_rs1", 64'(out_rs1), 64'(vt[i].rs1));
            chk("tbl_rs2", 64'(out_rs2), 64'(vt[i].rs2));
            chk("tbl_wd", 64'(out_wd), 64'(vt[i].wd));
            chk("tbl_wb_sel", 64'(out_wb_sel), 64'(vt[i].wb));
            chk("tbl_rf_wr_en", 64'(out_rf_wr_en), 64'(vt[i].rf));
            chk("tbl_mem_req", 64'(out_mem_req), 64'(vt[i].mem));
            chk("tbl_mem_type", 64'(out_mem_req_type), 64'(vt[i].mt));
            chk("tbl_busy", 64'(sb_busy), 64'(0));
        end
        idle(0);

        // RAW stall on x5 released by writeback.
        drv(1, mk(5, 0, 0, LD), 32'h200, 1, 0, 0, 0); cycle();
        drv(1, mk(6, 5, 0, OP), 32'h204, 1, 0, 0, 0); cycle();
        chk("raw_stall_ready", 64'(in_ready), 64'(0));
        chk("raw_busy5", 64'(sb_busy[5]), 64'(1));
        chk("raw_held", 64'(out_valid), 64'(0));
        drv(1, mk(6, 5, 0, OP), 32'h204, 1, 1, 5, 0); cycle();
        drv(1, mk(6, 5, 0, OP), 32'h204, 1, 0, 0, 0); cycle();
        chk("raw_accept", 64'(out_valid), 64'(1));
        chk("raw_rs1", 64'(out_rs1), 64'(5));
        chk("raw_wb_alu", 64'(out_wb_sel), 64'(1));
        idle(6);

        // Backpressure: bundle held stable for three cycles.
        drv(1, mk(8, 0, 0, OPI), 32'h300, 1, 0, 0, 0); cycle();
        drv(1, mk(9, 0, 0, OP), 32'h304, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_pc_stable", 64'(out_pc), 64'(32'h300));
            chk("bp_ready_low", 64'(in_ready), 64'(0));
        end
        drv(1, mk(9, 0, 0, OP), 32'h304, 1, 0, 0, 0);
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'(1));
        cycle();
        chk("bp_next_pc", 64'(out_pc), 64'(32'h304));
        idle(8);
        idle(9);

        // Saturation of x7 at three outstanding writes.
        for (int i = 0; i < 3; i++) begin
            drv(1, mk(7, 0, 0, OP), 32'h400 + 32'(i * 4), 1, 0, 0, 0); cycle();
        end
        drv(1, mk(7, 0, 0, OP), 32'h40C, 1, 0, 0, 0); cycle();
        chk("sat_stall_ready", 64'(in_ready), 64'(0));
        chk("sat_not_taken", 64'(out_valid), 64'(0));
        drv(1, mk(7, 0, 0, OP), 32'h40C, 1, 1, 7, 0); cycle();
        drv(1, mk(7, 0, 0, OP), 32'h40C, 1, 0, 0, 0); cycle();
        chk("sat_accept_pc", 64'(out_pc), 64'(32'h40C));
        for (int i = 0; i < 3; i++) idle(7);
        chk("sat_drained", 64'(sb_busy), 64'(0));

        // Flush rollback, then flush plus writeback clamping at zero.
        drv(1, mk(20, 0, 0, JAL), 32'h500, 0, 0, 0, 0); cycle();
        chk("fl_busy1", 64'(sb_busy[1]), 64'(1));
        drv(0, '0, '0, 0, 0, 0, 1); cycle();
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_rollback", 64'(sb_busy[1]), 64'(0));
        drv(1, mk(20, 0, 0, JAL), 32'h504, 0, 0, 0, 0); cycle();
        drv(0, '0, '0, 0, 1, 1, 1); cycle();
        chk("fl_clamp", 64'(sb_busy), 64'(0));
        drv(1, mk(20, 0, 0, JAL), 32'h508, 1, 0, 0, 1); cycle();
        chk("fl_no_accept", 64'(out_valid), 64'(0));

        // x0 destination never tracked.
        drv(1, mk(0, 0, 0, OP), 32'h600, 1, 0, 0, 0); cycle();
        chk("x0_busy", 64'(sb_busy), 64'(0));
        drv(1, mk(4, 0, 0, BAD), 32'h604, 1, 0, 0, 0); cycle();
        chk("bad_rf", 64'(out_rf_wr_en), 64'(0));
        chk("bad_busy", 64'(sb_busy), 64'(0));
`ifdef DECODE_ILLEGAL_EN
        chk("bad_illegal", 64'(out_illegal), 64'(1));
`endif

        // Reset asserted mid-cycle with a held bundle and a pending write.
        drv(1, mk(3, 0, 0, LD), 32'h700, 0, 0, 0, 0); cycle();
        #2 reset_n = 0;
        #1;
        model_clear();
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_busy", 64'(sb_busy), 64'(0));
        chk("rst_mid_ready", 64'(in_ready), 64'(0));
        drv(0, '0, '0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        idle(0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drv($urandom_range(0, 3) != 0,
                mk(rsel[$urandom_range(0, 4)], rsel[$urandom_range(0, 4)],
                   rsel[$urandom_range(0, 4)], ops[$urandom_range(0, 8)]),
                $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                rsel[$urandom_range(0, 4)], $urandom_range(0, 15) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised decode pipeline stage between fetch and execute.
- Decodes instruction fields and control as the existing combinational decoder does.
- Adds a per-register pending-write scoreboard that stalls on read-after-write hazards.
- Uses valid/ready handshakes on both sides and supports flush.

Parameters:
REG_AW, 5, register address width; register count is 2^REG_AW.
PEND_W, 2, per-register pending-write counter width; max outstanding writes per register = 2^PEND_W-1.
INST_W, 32, instruction width (field positions below are fixed for 32).
PC_W, 32, program counter width.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts this cycle
in_inst  in  INST_W  instruction
in_pc  in  PC_W  instruction PC
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts the bundle
out_pc  out  PC_W  registered PC
out_inst  out  INST_W  registered instruction
out_rs1  out  REG_AW  inst[26:22]
out_rs2  out  REG_AW  inst[21:17]
out_wd  out  REG_AW  1 for JAL, otherwise inst[31:27]
out_wb_sel  out  2  WB_ALU / WB_MEM / WB_PC4, otherwise 0
out_rf_wr_en  out  1  OP, OP_IMM, LUI, LOAD, JAL, JALR
out_mem_req  out  1  LOAD or STORE
out_mem_req_type  out  1  MEM_REQ_WRITE for STORE, otherwise MEM_REQ_READ
wb_valid  in  1  writeback retires one register write
wb_wd  in  REG_AW  retired destination register
flush  in  1  squash the held bundle
sb_busy  out  2^REG_AW  bit i set when pend[i] != 0

Behaviour:
- Reset (async, reset_n=0):
  - out_valid=0; all out_* registers 0; all pend counters 0.
  - in_ready=0 while reset_n=0.
- Source-operand use:
  - rs1 is used by OP, OP_IMM, LOAD, STORE, JALR, BRANCH.
  - rs2 is used by OP, STORE, BRANCH.
- Register x0 is never tracked: pend[0] is held at 0; a source or destination of 0 never creates a hazard and never increments.
- hazard is asserted when any of these holds:
  - rs1 is used and pend[rs1] != 0;
  - rs2 is used and pend[rs2] != 0;
  - rf_wr_en=1, wd != 0 and pend[wd] is saturated (all ones).
- in_ready = !hazard && !flush && (!out_valid || out_ready). It is combinational, from in_inst and state.
- Accept (in_valid && in_ready):
  - All out_* registers load the decoded fields; out_valid<=1 on the next edge. Latency is 1 cycle.
  - pend[wd] increments if rf_wr_en=1 and wd != 0.
- No accept and out_ready=1: out_valid<=0.
- No accept and out_ready=0: outputs hold, stable until taken.
- Writeback (wb_valid=1, wb_wd != 0): pend[wb_wd] decrements and saturates at 0; decrementing a zero counter has no effect and raises no error.
- Flush (flush=1):
  - out_valid<=0.
  - If out_valid && out_rf_wr_en && out_wd != 0, pend[out_wd] decrements (rollback).
  - No accept occurs in a flush cycle.
- Same-cycle events on one register are netted as +inc -wb -rollback, clamped to [0, max].
  - Example: accept-increment and writeback on the same register leave the count unchanged.
- Reset asserted mid-stall or with a held bundle discards everything; no partial state survives.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined:
  - Adds output out_illegal (1 bit, registered, reset 0).
  - Any opcode outside OP, OP_IMM, LUI, LOAD, STORE, JAL, JALR, BRANCH sets out_illegal=1 and forces rf_wr_en=0, mem_req=0 and wb_sel=0.
  - No scoreboard increment for such an instruction.
- Undefined:
  - Port absent.
  - Unknown opcodes pass through with wb_sel=0, rf_wr_en=0, mem_req=0.

Decomposition:
- consts.vh holds OPCODE_* (OPCODE_BRANCH is added there), WB_* and MEM_REQ_*.
- Sub-module decode_scoreboard holds the pend counter array, the netting/clamp logic, the sb_busy vector and the hazard lookup ports (rs1, rs2, wd).
- decode_stage holds the field decode and the pipeline register.

Test Plan:
- Reset: reset_n=0 asynchronously mid-cycle -> out_valid=0 and sb_busy=0 immediately; in_ready=0.
- RAW stall:
  - LOAD wd=5, then OP rs1=5 -> OP held with in_ready=0 and sb_busy[5]=1.
  - wb_valid=1, wb_wd=5 -> OP accepted next cycle; out_rs1=5, out_wb_sel=WB_ALU.
- Backpressure: out_ready=0 for 3 cycles with a valid bundle -> out_* stable and in_ready=0; out_ready=1 -> next instruction accepted the same cycle.
- Saturation:
  - Three accepted OPs with wd=7 (PEND_W=2) -> pend[7]=3; fourth is stalled.
  - One wb_wd=7 -> fourth accepted.
- Flush rollback: held JAL (out_wd=1) then flush=1 -> out_valid=0 and sb_busy[1]=0; flush together with wb_wd=1 -> counter clamps at 0.
- x0 and the optional feature:
  - OP with wd=0 -> sb_busy unchanged.
  - With DECODE_ILLEGAL_EN, opcode 7'h7F -> out_illegal=1, out_rf_wr_en=0, no sb_busy change.
